tilelink_ul_fifo_sync: RTL and testbench

TILELINK_UL_FIFO_SYNC -- requirements
Module: tilelink_ul_fifo_sync

---
 rtl/tilelink_ul_fifo_sync_pkg.sv | 58 +++++
 rtl/tilelink_ul_fifo_sync_fifo.sv | 81 ++++++++
 rtl/tilelink_ul_fifo_sync.sv | 74 +++++++
 tb/tb_tilelink_ul_fifo_sync.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tilelink_ul_fifo_sync_pkg.sv
// rtl/tilelink_ul_fifo_sync_pkg.sv - TL-UL channel structs and FIFO payload types
package TileLinkUL_pkg;

    localparam logic [2:0] TL_PUT_FULL       = 3'd0;
    localparam logic [2:0] TL_GET            = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK     = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DAT = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_m2s_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_s2m_t;

    typedef struct packed {
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
    } tl_a_payload_t;

    typedef struct packed {
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
    } tl_d_payload_t;

    // Occupancy width; a pass-through channel still gets a 1-bit port tied to 0.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tilelink_ul_fifo_sync_fifo.sv
// rtl/tilelink_ul_fifo_sync_fifo.sv - registered valid/ready FIFO, Depth 0 is a wire
module tilelink_ul_fifo
    import TileLinkUL_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      s_tvalid_i,
    output logic                      s_tready_o,
    input  logic [Width-1:0]          s_tdata_i,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic [Width-1:0]          m_tdata_o,
    output logic [cnt_w(Depth)-1:0]   depth_o
);

    localparam int unsigned CntW = cnt_w(Depth);

    if (Depth == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign m_tvalid_o     = s_tvalid_i;
        assign s_tready_o     = m_tready_i;
        assign m_tdata_o      = s_tdata_i;
        assign depth_o        = '0;
    end else begin : g_fifo
        localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

        logic [Width-1:0] mem_q [Depth];
        logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
        logic [CntW-1:0]  cnt_q, cnt_d;
        logic             push, pop;

        // Ready/valid come only from the counter, so no input-to-output paths exist.
        assign s_tready_o = (cnt_q != CntW'(Depth));
        assign m_tvalid_o = (cnt_q != '0);
        assign push       = s_tvalid_i & s_tready_o;
        assign pop        = m_tvalid_o & m_tready_i;
        assign m_tdata_o  = mem_q[rptr_q];
        assign depth_o    = cnt_q;

        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (push) begin
                wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
        end

        // Storage is deliberately left unreset.
        always_ff @(posedge clk_i) begin
            if (push && !rst_i) begin
                mem_q[wptr_q] <= s_tdata_i;
            end
        end
    end

endmodule

// File: rtl/tilelink_ul_fifo_sync.sv
// rtl/tilelink_ul_fifo_sync.sv - TL-UL A/D channel FIFO pair between host and bridge
module tilelink_ul_fifo_sync
    import TileLinkUL_pkg::*;
#(
    parameter int unsigned ReqDepth = 2,
    parameter int unsigned RspDepth = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  tl_m2s_t                       tl_h_i,
    output tl_s2m_t                       tl_h_o,
    output tl_m2s_t                       tl_d_o,
    input  tl_s2m_t                       tl_d_i,
    output logic [cnt_w(ReqDepth)-1:0]    req_depth_o,
    output logic [cnt_w(RspDepth)-1:0]    rsp_depth_o
);

    tl_a_payload_t a_in, a_out;
    tl_d_payload_t d_in, d_out;
    logic          a_valid, a_ready, d_valid, d_ready;

    assign a_in = '{a_opcode:  tl_h_i.a_opcode,  a_param: tl_h_i.a_param,
                    a_size:    tl_h_i.a_size,    a_source: tl_h_i.a_source,
                    a_address: tl_h_i.a_address, a_mask:  tl_h_i.a_mask,
                    a_data:    tl_h_i.a_data};

    assign d_in = '{d_opcode: tl_d_i.d_opcode, d_param: tl_d_i.d_param,
                    d_size:   tl_d_i.d_size,   d_source: tl_d_i.d_source,
                    d_sink:   tl_d_i.d_sink,   d_data:  tl_d_i.d_data,
                    d_error:  tl_d_i.d_error};

    tilelink_ul_fifo #(
        .Width ($bits(tl_a_payload_t)),
        .Depth (ReqDepth)
    ) u_req_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_tvalid_i (tl_h_i.a_valid),
        .s_tready_o (a_ready),
        .s_tdata_i  (a_in),
        .m_tvalid_o (a_valid),
        .m_tready_i (tl_d_i.a_ready),
        .m_tdata_o  (a_out),
        .depth_o    (req_depth_o)
    );

    tilelink_ul_fifo #(
        .Width ($bits(tl_d_payload_t)),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_tvalid_i (tl_d_i.d_valid),
        .s_tready_o (d_ready),
        .s_tdata_i  (d_in),
        .m_tvalid_o (d_valid),
        .m_tready_i (tl_h_i.d_ready),
        .m_tdata_o  (d_out),
        .depth_o    (rsp_depth_o)
    );

    assign tl_d_o = '{a_valid:   a_valid,         a_opcode: a_out.a_opcode,
                      a_param:   a_out.a_param,   a_size:   a_out.a_size,
                      a_source:  a_out.a_source,  a_address: a_out.a_address,
                      a_mask:    a_out.a_mask,    a_data:   a_out.a_data,
                      d_ready:   d_ready};

    assign tl_h_o = '{d_valid:   d_valid,         d_opcode: d_out.d_opcode,
                      d_param:   d_out.d_param,   d_size:   d_out.d_size,
                      d_source:  d_out.d_source,  d_sink:   d_out.d_sink,
                      d_data:    d_out.d_data,    d_error:  d_out.d_error,
                      a_ready:   a_ready};

endmodule

// File: tb/tb_tilelink_ul_fifo_sync.sv
// tb/tb_tilelink_ul_fifo_sync.sv - queue-model bench for buffered and pass-through builds
module tb_tilelink_ul_fifo_sync;
    import TileLinkUL_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    tl_m2s_t h_i;
    tl_s2m_t d_i;
    tl_s2m_t h_o, h0_o;
    tl_m2s_t d_o, d0_o;
    logic [1:0] req_depth, rsp_depth;
    logic       req_depth0, rsp_depth0;

    int checks = 0;
    int errors = 0;
    logic [127:0] qa[$];
    logic [127:0] qd[$];

    always #5 clk = ~clk;

    tilelink_ul_fifo_sync #(.ReqDepth(2), .RspDepth(2)) dut (
        .clk_i(clk), .rst_i(rst), .tl_h_i(h_i), .tl_h_o(h_o),
        .tl_d_o(d_o), .tl_d_i(d_i), .req_depth_o(req_depth), .rsp_depth_o(rsp_depth)
    );

    tilelink_ul_fifo_sync #(.ReqDepth(0), .RspDepth(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .tl_h_i(h_i), .tl_h_o(h0_o),
        .tl_d_o(d0_o), .tl_d_i(d_i), .req_depth_o(req_depth0), .rsp_depth_o(rsp_depth0)
    );

    function automatic logic [127:0] key_a(input tl_m2s_t m);
        return 128'({m.a_opcode, m.a_param, m.a_size, m.a_source, m.a_address, m.a_mask, m.a_data});
    endfunction

    function automatic logic [127:0] key_d(input tl_s2m_t s);
        return 128'({s.d_opcode, s.d_param, s.d_size, s.d_source, s.d_sink, s.d_data, s.d_error});
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_a();
        h_i.a_opcode  = ($urandom_range(0, 1) == 1) ? TL_GET : TL_PUT_FULL;
        h_i.a_param   = 3'($urandom);
        h_i.a_size    = 2'($urandom);
        h_i.a_source  = 8'($urandom);
        h_i.a_address = $urandom;
        h_i.a_mask    = 4'($urandom);
        h_i.a_data    = $urandom;
    endtask

    task automatic rand_d();
        d_i.d_opcode = ($urandom_range(0, 1) == 1) ? TL_ACCESS_ACK_DAT : TL_ACCESS_ACK;
        d_i.d_param  = 3'($urandom);
        d_i.d_size   = 2'($urandom);
        d_i.d_source = 8'($urandom);
        d_i.d_sink   = 1'($urandom);
        d_i.d_data   = $urandom;
        d_i.d_error  = 1'($urandom);
    endtask

    // Compare every output with the queue model, then advance the model on the clock edge.
    task automatic cycle();
        bit a_push, a_pop, d_push, d_pop;
        #1;
        chk("req_depth", 128'(req_depth), 128'(qa.size()));
        chk("rsp_depth", 128'(rsp_depth), 128'(qd.size()));
        chk("a_valid", 128'(d_o.a_valid), 128'(qa.size() != 0));
        chk("a_ready", 128'(h_o.a_ready), 128'(qa.size() != 2));
        chk("d_valid", 128'(h_o.d_valid), 128'(qd.size() != 0));
        chk("d_ready", 128'(d_o.d_ready), 128'(qd.size() != 2));
        if (qa.size() != 0) chk("a_head", key_a(d_o), qa[0]);
        if (qd.size() != 0) chk("d_head", key_d(h_o), qd[0]);
        chk("pt_a", {key_a(d0_o), 8'(d0_o.a_valid), 8'(d0_o.d_ready)},
            {key_a(h_i), 8'(h_i.a_valid), 8'(h_i.d_ready)});
        chk("pt_d", {key_d(h0_o), 8'(h0_o.d_valid), 8'(h0_o.a_ready)},
            {key_d(d_i), 8'(d_i.d_valid), 8'(d_i.a_ready)});
        chk("pt_depth", 128'({req_depth0, rsp_depth0}), 128'(0));
        a_push = h_i.a_valid && qa.size() < 2;
        a_pop  = d_i.a_ready && qa.size() > 0;
        d_push = d_i.d_valid && qd.size() < 2;
        d_pop  = h_i.d_ready && qd.size() > 0;
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qd.delete();
        end else begin
            if (a_pop)  void'(qa.pop_front());
            if (a_push) qa.push_back(key_a(h_i));
            if (d_pop)  void'(qd.pop_front());
            if (d_push) qd.push_back(key_d(d_i));
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        h_i = '0;
        d_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Idle after reset
        repeat (5) cycle();

        // Two Gets stall behind a blocked bridge, third request is refused
        h_i.a_valid = 1'b1; h_i.a_opcode = TL_GET; h_i.a_address = 32'h100;
        cycle();
        h_i.a_address = 32'h104;
        cycle();
        h_i.a_address = 32'h108;
        #1;
        chk("a_full_ready", 128'(h_o.a_ready), 128'(0));
        chk("a_full_depth", 128'(req_depth), 128'(2));
        cycle();
        h_i.a_valid = 1'b0; d_i.a_ready = 1'b1;
        #1;
        chk("a_first_addr", 128'(d_o.a_address), 128'h100);
        cycle();
        #1;
        chk("a_second_addr", 128'(d_o.a_address), 128'h104);
        cycle();
        cycle();

        // Streaming 8 beats, sources 0..7
        for (int i = 0; i < 8; i++) begin
            rand_a();
            h_i.a_valid = 1'b1; h_i.a_source = 8'(i);
            cycle();
        end
        h_i.a_valid = 1'b0;
        repeat (2) cycle();

        // Fill D FIFO with an errored response, then pop and offer in the same cycle
        d_i.d_valid = 1'b1; d_i.d_opcode = TL_ACCESS_ACK_DAT;
        d_i.d_data = 32'hDEADBEEF; d_i.d_error = 1'b1; h_i.d_ready = 1'b0;
        repeat (2) cycle();
        h_i.d_ready = 1'b1; d_i.d_data = 32'h11111111; d_i.d_error = 1'b0;
        #1;
        chk("d_full_ready", 128'(d_o.d_ready), 128'(0));
        chk("d_head_data", 128'({h_o.d_data, 7'd0, h_o.d_error}), 128'({32'hDEADBEEF, 8'd1}));
        cycle();
        d_i.d_valid = 1'b0;
        #1;
        chk("d_ready_after_pop", 128'(d_o.d_ready), 128'(1));
        chk("d_depth_after_pop", 128'(rsp_depth), 128'(1));
        repeat (3) cycle();

        // Reset with two entries queued in each channel and traffic still offered
        d_i.a_ready = 1'b0; h_i.d_ready = 1'b0;
        h_i.a_valid = 1'b1; d_i.d_valid = 1'b1;
        repeat (2) cycle();
        rst = 1'b1; d_i.a_ready = 1'b1; h_i.d_ready = 1'b1;
        cycle();
        rst = 1'b0; h_i.a_valid = 1'b0; d_i.d_valid = 1'b0;
        #1;
        chk("rst_a_valid", 128'(d_o.a_valid), 128'(0));
        chk("rst_req_depth", 128'(req_depth), 128'(0));
        repeat (4) cycle();

        // Randomized traffic on both channels
        for (int i = 0; i < 300; i++) begin
            rand_a();
            rand_d();
            h_i.a_valid = 1'($urandom_range(0, 1));
            h_i.d_ready = ($urandom_range(0, 3) != 0);
            d_i.a_ready = ($urandom_range(0, 2) == 0);
            d_i.d_valid = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
